hdlverifier_capture_buffer: RTL
===============================

Name: hdlverifier_capture_buffer

Overview:
Trigger-driven sample capture buffer. It is the consumer of the registered trigger produced by the capture comparator.
- After `arm`, it continuously records `data` into a circular RAM.
- A trigger freezes a window holding `trigger_position` pre-trigger samples and DEPTH-`trigger_position` samples from the trigger sample onward.
- The window is then streamed out, oldest first, over a valid/ready interface to the host-side readout logic.

Parameters:
- WIDTH, 8, sample width; matches the comparator's WIDTH.
- ADDR_WIDTH, 10, log2 of capture depth; DEPTH = 2**ADDR_WIDTH = 1024.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clk_enable  input  1  sample qualifier; capture-side state advances only when high.
- data  input  WIDTH  sample stream, same stream the comparator sees.
- trigger  input  1  comparator output, registered; high on cycle t means data at t-1 matched.
- arm  input  1  single-cycle pulse; starts a capture from IDLE or DONE.
- trigger_position  input  ADDR_WIDTH  number of pre-trigger samples; latched on arm.
- armed  output  1  high in FILL and WAIT.
- triggered  output  1  high in POST and DONE.
- capture_done  output  1  high in DONE.
- rd_data  output  WIDTH  readout sample.
- rd_valid  output  1  rd_data valid.
- rd_ready  input  1  consumer accepts when rd_valid && rd_ready.
- rd_last  output  1  qualifies the final (DEPTH-th) readout word.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; write pointer, counters and readout pointer 0. Reset mid-capture or mid-readout aborts with no residual state. RAM contents are not cleared.
- Alignment: `data` passes through a 1-cycle delay register, gated by clk_enable, before the RAM write port. The sample written in the cycle trigger is seen is therefore exactly the matching sample.
- States:
  - IDLE: arm -> FILL. On arm, latch P = trigger_position, clear the pre-count, set wr_ptr = 0.
  - FILL: write every enabled cycle and increment wr_ptr (wraps modulo DEPTH). Leave to WAIT when the pre-count reaches P. A trigger during FILL is ignored. P=0 means FILL lasts 0 cycles: arm goes straight to WAIT.
  - WAIT: write every enabled cycle. An enabled cycle with trigger=1 records trig_addr = the current wr_ptr, writes that sample, sets post_cnt = 1, and moves to POST. If DEPTH-P = 1, it goes straight to DONE instead.
  - POST: write every enabled cycle and increment post_cnt. When post_cnt reaches DEPTH-P, go to DONE, with the final write in that same cycle. Trigger is ignored.
  - DONE: writes stop. rd_ptr starts at start_addr = trig_addr - P (modulo DEPTH).
- Readout (DONE only; not gated by clk_enable):
  - RAM read latency is 1 cycle. rd_valid rises 2 cycles after entering DONE.
  - rd_data/rd_valid hold stable while rd_valid && !rd_ready.
  - Each handshake advances rd_ptr by 1 (wraps).
  - rd_last is high on word DEPTH-1, counting from 0. After that handshake rd_valid drops and stays 0; the state remains DONE.
- clk_enable=0: no writes and no pointer/counter/state changes on the capture side. arm and trigger are ignored while clk_enable=0.
- arm while FILL/WAIT/POST is ignored.
- arm while DONE abandons the readout: rd_valid drops the next cycle and a new capture starts with a new P latch.
- Width rule: trigger_position values are 0..DEPTH-1. All pointer arithmetic is unsigned ADDR_WIDTH-bit modulo DEPTH. Counters are ADDR_WIDTH+1 bits.

Decomposition:
- Package hdlverifier_capture_pkg holds:
  - the state enum (IDLE, FILL, WAIT, POST, DONE);
  - a DEPTH localparam function of ADDR_WIDTH.
- One sub-module, hdlverifier_capture_ram: simple dual-port RAM with 1 write port and 1 registered read port, parameterised WIDTH/ADDR_WIDTH, inferring block RAM.

Test Plan:
- Reset mid-POST: reset_n=0 for 1 cycle during POST -> all outputs 0 immediately; state IDLE. A subsequent arm captures correctly.
- Basic window: ADDR_WIDTH=4 (DEPTH=16), P=4, data = incrementing counter from 0. Trigger asserted when data==20 matched. Readout -> 16 words 16..31, rd_last on the word 31.
- P=0: DEPTH=16, trigger on sample 7 -> readout starts at 7 and gives 7..22. A trigger pulse during arm's cycle is honoured.
- Trigger during FILL: P=8, trigger on the 3rd sample after arm, then on sample 40 -> the first trigger is ignored and the window is centred on 40 (32..47).
- Backpressure and clk_enable:
  - rd_ready toggles randomly and clk_enable has a 50% duty during capture -> the readout sequence matches a golden model built from enabled samples only.
  - rd_data holds while stalled.
- Re-arm during DONE: arm after 5 words have been read -> rd_valid drops the next cycle, armed=1, and the second capture is correct.

Source files
------------

// File: rtl/hdlverifier_capture_buffer_pkg.sv
// Shared types and sizing helpers for the trigger-driven capture buffer.
package hdlverifier_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } capture_state_e;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/hdlverifier_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module hdlverifier_capture_ram
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; output holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/hdlverifier_capture_buffer.sv
// Trigger-driven capture buffer: circular recording, window freeze on trigger,
// and oldest-first valid/ready readout of the frozen window.
module hdlverifier_capture_buffer
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic [WIDTH-1:0]      data,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] trigger_position,
  output logic                  armed,
  output logic                  triggered,
  output logic                  capture_done,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ZERO  = CW'(32'd0);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(32'd0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(32'd1);

  capture_state_e state;
  logic [WIDTH-1:0]      data_d;
  logic [ADDR_WIDTH-1:0] p_r;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [CW-1:0]         pre_cnt;
  logic [CW-1:0]         post_cnt;

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         fetch_cnt;
  logic                  q_valid;
  logic                  q_last;
  logic [WIDTH-1:0]      ram_q;

  logic                  arm_start;
  logic                  wait_cycle;
  logic                  trig_hit;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] p_eff;
  logic [CW-1:0]         post_len;
  logic                  done_entry;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  out_load;
  logic                  q_free;
  logic                  rd_en;

  assign armed        = (state == S_FILL) || (state == S_WAIT);
  assign triggered    = (state == S_POST) || (state == S_DONE);
  assign capture_done = (state == S_DONE);

  // Capture-side decode. With P=0 the arm cycle itself behaves as a WAIT
  // cycle, so a trigger coincident with arm is honoured at address 0.
  always_comb begin
    arm_start  = clk_enable && arm && ((state == S_IDLE) || (state == S_DONE));
    p_eff      = arm_start ? trigger_position : p_r;
    post_len   = DEPTH_CNT - {1'b0, p_eff};
    wait_cycle = clk_enable && ((state == S_WAIT) ||
                                (arm_start && (trigger_position == ADDR_ZERO)));
    trig_hit   = wait_cycle && trigger;
    wr_addr    = arm_start ? ADDR_ZERO : wr_ptr;
    wr_en      = (clk_enable && ((state == S_FILL) || (state == S_POST))) || wait_cycle;
    if (trig_hit && (post_len == CNT_ONE)) begin
      done_entry = 1'b1;
      start_addr = wr_addr - p_eff;
    end else if (clk_enable && (state == S_POST) && ((post_cnt + CNT_ONE) == post_len)) begin
      done_entry = 1'b1;
      start_addr = trig_addr - p_r;
    end else begin
      done_entry = 1'b0;
      start_addr = trig_addr - p_r;
    end
  end

  // Readout pipeline decode: RAM output stage feeds the rd_* output stage.
  always_comb begin
    out_load = q_valid && (!rd_valid || rd_ready);
    q_free   = !q_valid || out_load;
    rd_en    = (state == S_DONE) && !arm_start && (fetch_cnt < DEPTH_CNT) && q_free;
  end

  // Capture FSM: sample delay, write pointer, window counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      data_d    <= {WIDTH{1'b0}};
      p_r       <= ADDR_ZERO;
      wr_ptr    <= ADDR_ZERO;
      trig_addr <= ADDR_ZERO;
      pre_cnt   <= CNT_ZERO;
      post_cnt  <= CNT_ZERO;
    end else begin
      if (clk_enable) begin
        data_d <= data;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (arm_start) begin
            p_r      <= trigger_position;
            pre_cnt  <= CNT_ZERO;
            post_cnt <= CNT_ZERO;
            if (trigger_position == ADDR_ZERO) begin
              wr_ptr <= ADDR_ONE;
              if (trigger) begin
                trig_addr <= ADDR_ZERO;
                post_cnt  <= CNT_ONE;
                state     <= S_POST;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              wr_ptr <= ADDR_ZERO;
              state  <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (clk_enable) begin
            wr_ptr  <= wr_ptr + ADDR_ONE;
            pre_cnt <= pre_cnt + CNT_ONE;
            if ((pre_cnt + CNT_ONE) == {1'b0, p_r}) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (clk_enable) begin
            wr_ptr <= wr_ptr + ADDR_ONE;
            if (trigger) begin
              trig_addr <= wr_ptr;
              post_cnt  <= CNT_ONE;
              state     <= (post_len == CNT_ONE) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (clk_enable) begin
            wr_ptr   <= wr_ptr + ADDR_ONE;
            post_cnt <= post_cnt + CNT_ONE;
            if (done_entry) begin
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Readout pointer, fetch stage and registered rd_* outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= ADDR_ZERO;
      fetch_cnt <= CNT_ZERO;
      q_valid   <= 1'b0;
      q_last    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= {WIDTH{1'b0}};
    end else if (arm_start || done_entry) begin
      rd_ptr    <= start_addr;
      fetch_cnt <= CNT_ZERO;
      q_valid   <= 1'b0;
      q_last    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr    <= rd_ptr + ADDR_ONE;
        fetch_cnt <= fetch_cnt + CNT_ONE;
        q_valid   <= 1'b1;
        q_last    <= (fetch_cnt == (DEPTH_CNT - CNT_ONE));
      end else if (out_load) begin
        q_valid <= 1'b0;
        q_last  <= 1'b0;
      end
      if (out_load) begin
        rd_valid <= 1'b1;
        rd_data  <= ram_q;
        rd_last  <= q_last;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  hdlverifier_capture_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_d),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

endmodule
